// File: rtl/four_bit_csa_pkg.sv
// four_bit_csa_pkg: shared widths and reset value for the 4-bit carry-select adder
package four_bit_csa_pkg;
    localparam int CSA_WIDTH       = 4;
    localparam int CSA_GROUP_WIDTH = 2;
    localparam logic [CSA_WIDTH:0] CSA_OUT_RST = 5'b0;
endpackage

// File: rtl/four_bit_csa_full_adder.sv
// full_adder: single-bit full adder
// Ports: a, b, cin -> s (sum), cout (carry)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/four_bit_csa.sv
// four_bit_csa: 4-bit carry-select adder {Cout,s3..s0} = x + y + Cin
// Ports: clk, rst (async active-high) drive only the optional output register;
//        x0..x3, y0..y3 operands (bit 0 = LSB), Cin carry-in;
//        s0..s3 sum (bit 0 = LSB), Cout carry-out.
// Macro FOUR_BIT_CSA_OUT_REG_EN: when defined, outputs are registered (1-cycle latency).
module four_bit_csa
    import four_bit_csa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic Cin,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic Cout
);
    logic [CSA_WIDTH-1:0]        x_v, y_v;
    logic [CSA_GROUP_WIDTH:0]    c_lo;
    logic [CSA_GROUP_WIDTH-1:0]  s_lo;
    logic [1:0][CSA_GROUP_WIDTH:0]   c_hi;
    logic [1:0][CSA_GROUP_WIDTH-1:0] s_hi;
    logic [CSA_WIDTH:0]          sum_d;
    logic [CSA_WIDTH:0]          sum_o;

    assign x_v = {x3, x2, x1, x0};
    assign y_v = {y3, y2, y1, y0};

    assign c_lo[0] = Cin;
    for (genvar i = 0; i < CSA_GROUP_WIDTH; i++) begin : g_lo
        full_adder u_fa (
            .a   (x_v[i]),
            .b   (y_v[i]),
            .cin (c_lo[i]),
            .s   (s_lo[i]),
            .cout(c_lo[i+1])
        );
    end

    // Copy k of the high group assumes carry-in k; c2 picks the real one.
    for (genvar k = 0; k < 2; k++) begin : g_hi
        assign c_hi[k][0] = 1'(k);
        for (genvar i = 0; i < CSA_GROUP_WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .a   (x_v[CSA_GROUP_WIDTH+i]),
                .b   (y_v[CSA_GROUP_WIDTH+i]),
                .cin (c_hi[k][i]),
                .s   (s_hi[k][i]),
                .cout(c_hi[k][i+1])
            );
        end
    end

    always_comb begin
        sum_d = c_lo[CSA_GROUP_WIDTH]
              ? {c_hi[1][CSA_GROUP_WIDTH], s_hi[1], s_lo}
              : {c_hi[0][CSA_GROUP_WIDTH], s_hi[0], s_lo};
    end

`ifdef FOUR_BIT_CSA_OUT_REG_EN
    logic [CSA_WIDTH:0] sum_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= CSA_OUT_RST;
        else     sum_q <= sum_d;
    end
    assign sum_o = sum_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign sum_o = sum_d;
`endif

    assign {Cout, s3, s2, s1, s0} = sum_o;
endmodule

// File: tb/tb_four_bit_csa.sv
// tb_four_bit_csa: directed and exhaustive self-checking bench for four_bit_csa
module tb_four_bit_csa;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x0 = 0, x1 = 0, x2 = 0, x3 = 0;
    logic y0 = 0, y1 = 0, y2 = 0, y3 = 0;
    logic Cin = 0;
    logic s0, s1, s2, s3, Cout;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    four_bit_csa dut (
        .clk(clk), .rst(rst),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .Cin(Cin),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .Cout(Cout)
    );

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        {x3, x2, x1, x0} = a;
        {y3, y2, y1, y0} = b;
        Cin = c;
    endtask

    // Apply a vector and compare once the result is due.
    task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [4:0] exp);
        drive(a, b, c);
`ifdef FOUR_BIT_CSA_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #2;
`endif
        check(tag, {Cout, s3, s2, s1, s0}, exp);
    endtask

    initial begin
        drive(4'd0, 4'd0, 1'b0);
        #2;
        check("reset_state", {Cout, s3, s2, s1, s0}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        vec("0+0+0",   4'd0,  4'd0,  1'b0, 5'b00000);
        vec("1+1+0",   4'd1,  4'd1,  1'b0, 5'b00010);
        vec("1+0+1",   4'd1,  4'd0,  1'b1, 5'b00010);
        vec("3+1+1",   4'd3,  4'd1,  1'b1, 5'b00101);
        vec("3+3+0",   4'd3,  4'd3,  1'b0, 5'b00110);
        vec("5+14+1",  4'd5,  4'd14, 1'b1, 5'b10100);
        vec("13+9+0",  4'd13, 4'd9,  1'b0, 5'b10110);
        vec("14+9+1",  4'd14, 4'd9,  1'b1, 5'b11000);
        vec("2+14+1",  4'd2,  4'd14, 1'b1, 5'b10001);
        vec("15+15+0", 4'd15, 4'd15, 1'b0, 5'b11110);
        vec("15+15+1", 4'd15, 4'd15, 1'b1, 5'b11111);

        for (int i = 0; i < 512; i++) begin
            logic [3:0] a, b;
            logic c;
            a = 4'(i);
            b = 4'(i >> 4);
            c = 1'(i >> 8);
            vec("sweep", a, b, c, 5'(a) + 5'(b) + 5'(c));
        end

`ifdef FOUR_BIT_CSA_OUT_REG_EN
        vec("pre_rst", 4'd15, 4'd15, 1'b1, 5'b11111);
        drive(4'd9, 4'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {Cout, s3, s2, s1, s0}, 5'b00000);
        @(posedge clk);
        #1;
        check("rst_held", {Cout, s3, s2, s1, s0}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_released", {Cout, s3, s2, s1, s0}, 5'b00000);
        @(posedge clk);
        #1;
        check("first_edge", {Cout, s3, s2, s1, s0}, 5'b01101);
`else
        drive(4'd9, 4'd4, 1'b0);
        rst = 1'b1;
        #2;
        check("rst_no_effect", {Cout, s3, s2, s1, s0}, 5'b01101);
        @(posedge clk);
        #1;
        check("clk_no_effect", {Cout, s3, s2, s1, s0}, 5'b01101);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/four_bit_csa.md
# four_bit_csa

4-bit carry-select adder computing {Cout, s3..s0} = x + y + Cin from bit-scalar operand ports. Used as the 4-bit building block of the team's 16-bit carry-select adder, where Cout of one block feeds Cin of the next. The sum path is combinational by default. An optional output register stage can be compiled in, and it uses the clock and reset.

## Interface

No parameters. The width is fixed at 4.

Clock and reset are one clock and an asynchronous, active-high reset:

- clk  input  1  rising-edge clock; used only by the optional output register.
- rst  input  1  asynchronous, active-high reset of the optional output register.

Operand and result ports:

- x0, x1, x2, x3  input  1 each  operand x. x0 is the LSB (weight 1) and x3 the MSB (weight 8).
- y0, y1, y2, y3  input  1 each  operand y. y0 is the LSB and y3 the MSB.
- Cin  input  1  carry-in, weight 1.
- s0, s1, s2, s3  output  1 each  sum bits. s0 is the LSB.
- Cout  output  1  carry-out, weight 16.

## Operation

- Unsigned addition: {Cout,s3,s2,s1,s0} = {x3..x0} + {y3..y0} + Cin.
  - Range is 0..31; there is no overflow beyond Cout.
- Carry-select organisation in two 2-bit groups:
  - Low group (bits 1:0): ripple-carry from Cin, giving s1,s0 and the group carry c2.
  - High group (bits 3:2): two ripple-carry copies, one with carry-in 0 and one with carry-in 1. Each produces sum bits and a carry.
  - c2 selects which copy drives s3, s2 and Cout.
- Each bit is a full adder: s = a^b^c, cout = a&b | c&(a^b).
- There is no state in the default build. The outputs are a pure function of the current inputs.
- X or Z on any input may propagate to the outputs. No masking is done.

## Timing

- Default build (macro undefined):
  - Combinational, with zero cycles of latency.
  - Outputs are valid within one combinational settle time after the inputs change.
  - The critical path is the low-group ripple plus one 2:1 mux.
  - clk and rst are present but have no effect.
- Registered build (macro defined):
  - s3..s0 and Cout are registered on the rising edge of clk, giving a latency of exactly 1 cycle.
  - A new operand set may be applied every cycle.
  - While rst=1, all outputs are 0 immediately, independent of clk.
  - When rst is released, the outputs stay 0 until the first rising edge after release. At that edge they take the sum of the inputs present.
  - Reset asserted mid-operation discards the pending result.

## Configuration

- Macro FOUR_BIT_CSA_OUT_REG_EN.
  - Defined: the output register stage described under Timing is instantiated.
  - Undefined: the outputs are driven directly by the adder logic, and clk and rst are unused.
- The port list is identical in both builds.

## Structure

- Shared package four_bit_csa_pkg holds:
  - CSA_WIDTH = 4
  - CSA_GROUP_WIDTH = 2
  - the output reset value 5'b0
- One sub-module, full_adder (a, b, cin -> s, cout). It is instantiated 2× in the low group and 4× in the high group (two copies of 2 bits).
- The top level packs the scalar ports into internal vectors, instantiates the groups and the select muxes, and contains the optional register block.

## Test plan

All expected values are for the default build. In the registered build, check the same values one cycle later.

- 0+0, Cin=0 -> s=0000, Cout=0.
- 1+1, Cin=0 -> s=0010, Cout=0. Then x=1, y=0, Cin=1 -> s=0010, Cout=0.
- 3+1+Cin and 3+3:
  - 3+1, Cin=1 -> s=0101, Cout=0.
  - 3+3, Cin=0 -> s=0110, Cout=0.
- Carry-select both ways:
  - 5+14, Cin=1 -> s=0100, Cout=1.
  - 13+9, Cin=0 -> s=0110, Cout=1.
  - 14+9, Cin=1 -> s=1000, Cout=1.
  - 2+14, Cin=1 -> s=0001, Cout=1.
- Maximum: 15+15, Cin=0 -> s=1110, Cout=1. Then 15+15, Cin=1 -> s=1111, Cout=1.
- Exhaustive sweep of all 512 {Cin,x,y} combinations against a reference model. In the registered build, additionally:
  - assert rst mid-stream and check that the outputs go to 0 asynchronously;
  - check that they remain 0 until the first edge after release.
